// File: rtl/alu_exec_unit_if.sv
// ----------------------------------------------------------------------------
// alu_exec_unit_if
// Request/response bundle between the KGP-RISC control path and the
// multi-cycle execute unit.
//   Request  (master -> slave): in_valid, alucode, op_a, op_b
//   Request  (slave -> master): in_ready
//   Response (slave -> master): out_valid, result, carry, zero, sign, illegal
//   Response (master -> slave): out_ready
// ----------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alucode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             sign;
    logic             illegal;

    // Requester side (control FSM / testbench)
    modport master (
        output in_valid, alucode, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, carry, zero, sign, illegal
    );

    // Execute unit side
    modport slave (
        input  in_valid, alucode, op_a, op_b, out_ready,
        output in_ready, out_valid, result, carry, zero, sign, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle execute unit. Add/AND/XOR/complement and illegal codes finish
// one cycle after acceptance; shifts walk one bit position per cycle so a
// shift by n finishes n cycles later than a single-cycle op. Results and flags
// are registered and held stable until the consumer takes them.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - alu_exec_unit_if.slave (valid/ready request and response)
// ----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_exec_unit_if.slave       bus
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SHLL = 4'b0100;
    localparam logic [3:0] OP_COMP = 4'b0101;
    localparam logic [3:0] OP_SHRL = 4'b0110;
    localparam logic [3:0] OP_SHRA = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    // Single-cycle datapath: returns {carry, result}. Illegal codes and the
    // shift codes (handled elsewhere) yield all zeros.
    function automatic logic [WIDTH:0] alu_single(
        input logic [3:0]       code,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] r;
        r = {(WIDTH+1){1'b0}};
        case (code)
            OP_ADD, OP_ADDI: r = {1'b0, a} + {1'b0, b};
            OP_AND:          r = {1'b0, a & b};
            OP_XOR:          r = {1'b0, a ^ b};
            // Carry out of ~b+1 is set only when ~b is all ones, i.e. b == 0.
            OP_COMP:         r = {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            default:         r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic is_shift(input logic [3:0] code);
        logic s;
        case (code)
            OP_SHLL, OP_SHRL, OP_SHRA: s = 1'b1;
            default:                   s = 1'b0;
        endcase
        return s;
    endfunction

    // One bit position of the iterative shifter. SHRA fills from the MSB
    // captured at acceptance, not from the partially shifted value.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [3:0]       code,
        input logic [WIDTH-1:0] v,
        input logic             fill
    );
        logic [WIDTH-1:0] r;
        case (code)
            OP_SHLL: r = {v[WIDTH-2:0], 1'b0};
            OP_SHRL: r = {1'b0, v[WIDTH-1:1]};
            OP_SHRA: r = {fill, v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    state_e           state_q,     state_d;
    logic [3:0]       code_q,      code_d;
    logic [WIDTH-1:0] sh_q,        sh_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             fill_q,      fill_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_q,     carry_d;
    logic             zero_q,      zero_d;
    logic             sign_q,      sign_d;
    logic             illegal_q,   illegal_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;

    logic             load_s;
    logic [WIDTH-1:0] load_val_s;
    logic             load_carry_s;
    logic             load_ill_s;
    logic [WIDTH:0]   single_s;
    logic [WIDTH-1:0] step_s;
    logic [CW-1:0]    amt_s;

    // Next-state and next-output computation for the execute FSM.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        out_valid_d  = out_valid_q;
        in_ready_d   = in_ready_q;
        load_s       = 1'b0;
        load_val_s   = {WIDTH{1'b0}};
        load_carry_s = 1'b0;
        load_ill_s   = 1'b0;
        single_s     = alu_single(bus.alucode, bus.op_a, bus.op_b);
        step_s       = shift_step(code_q, sh_q, fill_q);
        amt_s        = bus.op_b[CW-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    code_d = bus.alucode;
                    sh_d   = bus.op_a;
                    cnt_d  = amt_s;
                    fill_d = bus.op_a[WIDTH-1];
                    if (is_shift(bus.alucode) && (amt_s != {CW{1'b0}})) begin
                        state_d    = S_SHIFT;
                        in_ready_d = 1'b0;
                    end else if (is_shift(bus.alucode)) begin
                        // Zero-length shift passes op_a straight through.
                        load_s     = 1'b1;
                        load_val_s = bus.op_a;
                    end else begin
                        load_s       = 1'b1;
                        load_val_s   = single_s[WIDTH-1:0];
                        load_carry_s = single_s[WIDTH];
                        load_ill_s   = bus.alucode[3];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                sh_d  = step_s;
                cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    load_s     = 1'b1;
                    load_val_s = step_s;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        // Flags are computed from the value being registered so they always
        // describe the held result.
        if (load_s) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            result_d    = load_val_s;
            carry_d     = load_carry_s;
            illegal_d   = load_ill_s;
            zero_d      = (load_val_s == {WIDTH{1'b0}});
            sign_d      = load_val_s[WIDTH-1];
        end else begin
            result_d    = result_q;
            carry_d     = carry_q;
            illegal_d   = illegal_q;
            zero_d      = zero_q;
            sign_d      = sign_q;
        end
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= 4'b0000;
            sh_q        <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            fill_q      <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // in_ready is masked while reset is held so nothing is offered mid-reset.
    assign bus.in_ready  = in_ready_q & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.sign      = sign_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed and randomized bench for alu_exec_unit. Expected values come from
// a behavioural model written with plain SystemVerilog arithmetic operators.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_exec_unit_if #(.WIDTH(32)) bus_if ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: result, carry, illegal flag and latency in cycles.
    task automatic model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic ill,
                         output int lat);
        logic [32:0] sum;
        int n;
        n   = int'(b[4:0]);
        r   = 32'h0;
        c   = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (code)
            4'd0, 4'd1: begin sum = 33'(a) + 33'(b); r = sum[31:0]; c = sum[32]; end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: begin r = a << n; lat = 1 + n; end
            4'd5: begin r = 32'h0 - b; c = (b == 32'h0); end
            4'd6: begin r = a >> n; lat = 1 + n; end
            4'd7: begin r = $unsigned($signed(a) >>> n); lat = 1 + n; end
            default: ill = 1'b1;
        endcase
    endtask

    // Issue one request, wait for the response and check it, then retire it.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] er;
        logic        ec;
        logic        ei;
        int          lat;
        int          cyc;
        bit          ir_bad;
        model(code, a, b, er, ec, ei, lat);
        check({tag, "_in_ready_idle"}, 64'(bus_if.in_ready), 64'd1);
        bus_if.in_valid = 1'b1;
        bus_if.alucode  = code;
        bus_if.op_a     = a;
        bus_if.op_b     = b;
        tick();
        // Scramble inputs: the unit must ignore them once the request is taken.
        bus_if.in_valid = 1'b0;
        bus_if.alucode  = 4'($urandom);
        bus_if.op_a     = $urandom;
        bus_if.op_b     = $urandom;
        cyc    = 1;
        ir_bad = 1'b0;
        while (bus_if.out_valid !== 1'b1 && cyc < 40) begin
            if (bus_if.in_ready !== 1'b0) ir_bad = 1'b1;
            tick();
            cyc++;
        end
        check({tag, "_latency"},   64'(cyc), 64'(lat));
        check({tag, "_busy_ready"}, 64'(ir_bad), 64'd0);
        check({tag, "_out_valid"}, 64'(bus_if.out_valid), 64'd1);
        check({tag, "_in_ready_done"}, 64'(bus_if.in_ready), 64'd0);
        check({tag, "_result"},  64'(bus_if.result),  64'(er));
        check({tag, "_carry"},   64'(bus_if.carry),   64'(ec));
        check({tag, "_zero"},    64'(bus_if.zero),    64'(er == 32'h0));
        check({tag, "_sign"},    64'(bus_if.sign),    64'(er[31]));
        check({tag, "_illegal"}, 64'(bus_if.illegal), 64'(ei));
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check({tag, "_retired_valid"}, 64'(bus_if.out_valid), 64'd0);
        check({tag, "_retired_ready"}, 64'(bus_if.in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rc;
        int          cyc;
        checks = 0;
        errors = 0;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.alucode   = 4'h0;
        bus_if.op_a      = 32'h0;
        bus_if.op_b      = 32'h0;
        bus_if.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus_if.in_ready),  64'd0);
        check("rst_result",    64'(bus_if.result),    64'd0);
        check("rst_zero",      64'(bus_if.zero),      64'd0);
        check("rst_flags",     64'({bus_if.carry, bus_if.sign, bus_if.illegal}), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(bus_if.in_ready), 64'd1);

        // Directed boundary cases
        run_op(4'b0000, 32'hFFFF_FFFF, 32'h1, "add_wrap");
        run_op(4'b0001, 32'hFFFF_FFFF, 32'h1, "addi_wrap");
        run_op(4'b0101, 32'h0, 32'h5, "comp5");
        run_op(4'b0101, 32'h0, 32'h0, "comp0");
        run_op(4'b0111, 32'h8000_0000, 32'h4, "shra4");
        run_op(4'b0100, 32'h1234_5678, 32'h0, "shll0");
        run_op(4'b0110, 32'h8000_0000, 32'd31, "shrl31");
        run_op(4'b1101, 32'h1234, 32'h1234, "illegal");
        run_op(4'b0011, 32'hA5A5_0000, 32'h5A5A_00FF, "xor_clr_ill");

        // Backpressure: result must stay frozen and no new request accepted
        bus_if.in_valid = 1'b1;
        bus_if.alucode  = 4'b0010;
        bus_if.op_a     = 32'hF0F0_F0F0;
        bus_if.op_b     = 32'hFF00_FF00;
        tick();
        check("bp_valid", 64'(bus_if.out_valid), 64'd1);
        check("bp_result", 64'(bus_if.result), 64'h0000_0000_F000_F000);
        for (int i = 0; i < 3; i++) begin
            bus_if.alucode = 4'b0011;
            bus_if.op_a    = $urandom;
            bus_if.op_b    = $urandom;
            tick();
            check("bp_hold_result", 64'(bus_if.result), 64'h0000_0000_F000_F000);
            check("bp_hold_valid",  64'(bus_if.out_valid), 64'd1);
            check("bp_hold_ready",  64'(bus_if.in_ready), 64'd0);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check("bp_release_ready", 64'(bus_if.in_ready), 64'd1);
        check("bp_release_valid", 64'(bus_if.out_valid), 64'd0);

        // Reset in the middle of a shift
        bus_if.in_valid = 1'b1;
        bus_if.alucode  = 4'b0100;
        bus_if.op_a     = 32'h0000_0003;
        bus_if.op_b     = 32'd10;
        tick();
        bus_if.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready_low", 64'(bus_if.in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_valid",   64'(bus_if.out_valid), 64'd0);
        check("midrst_outputs", 64'({bus_if.result, bus_if.carry, bus_if.zero,
                                     bus_if.sign, bus_if.illegal}), 64'd0);
        check("midrst_in_ready", 64'(bus_if.in_ready), 64'd1);
        cyc = 0;
        while (bus_if.out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("midrst_no_stray_result", 64'(bus_if.out_valid), 64'd0);
        run_op(4'b0011, 32'hDEAD_BEEF, 32'h0F0F_0F0F, "xor_after_rst");

        // Randomized operations against the model
        for (int k = 0; k < 40; k++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (k % 5 == 0) rb = 32'h0;
            run_op(rc, ra, rb, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
